// File: rtl/ntm_matrix_adder_pkg.sv
// Shared types for the matrix adder operand feeder: sequencer states and element type.
package ntm_matrix_adder_pkg;

    localparam int DEFAULT_DATA_SIZE = 8;

    typedef logic [DEFAULT_DATA_SIZE-1:0] elem_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        STREAM = 2'd2,
        DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/ntm_matrix_adder_buffer.sv
// Paired A/B operand storage: one synchronous write port, one combinational read port,
// both addressed by (row, column) in row-major layout.
module ntm_matrix_adder_buffer #(
    parameter int DATA_SIZE  = 8,
    parameter int SIZE_I     = 4,
    parameter int SIZE_J     = 4,
    parameter int INDEX_SIZE = 4
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [INDEX_SIZE-1:0] wr_i,
    input  logic [INDEX_SIZE-1:0] wr_j,
    input  logic [DATA_SIZE-1:0]  wr_a,
    input  logic [DATA_SIZE-1:0]  wr_b,
    input  logic [INDEX_SIZE-1:0] rd_i,
    input  logic [INDEX_SIZE-1:0] rd_j,
    output logic [DATA_SIZE-1:0]  rd_a,
    output logic [DATA_SIZE-1:0]  rd_b
);

    localparam int DEPTH  = SIZE_I * SIZE_J;
    localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_SIZE-1:0] mem_a [DEPTH];
    logic [DATA_SIZE-1:0] mem_b [DEPTH];
    logic [ADDR_W-1:0]    wr_addr;
    logic [ADDR_W-1:0]    rd_addr;

    function automatic logic [ADDR_W-1:0] flat_addr(input logic [INDEX_SIZE-1:0] row,
                                                     input logic [INDEX_SIZE-1:0] col);
        return ADDR_W'(int'(row) * SIZE_J + int'(col));
    endfunction

    assign wr_addr = flat_addr(wr_i, wr_j);
    assign rd_addr = flat_addr(rd_i, rd_j);

    // Contents are deliberately not reset; every slot is rewritten before it is read.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_a[wr_addr] <= wr_a;
            mem_b[wr_addr] <= wr_b;
        end
    end

    assign rd_a = mem_a[rd_addr];
    assign rd_b = mem_b[rd_addr];

endmodule

// File: rtl/ntm_matrix_adder_feeder.sv
// Operand sequencer for the registered element adder: loads A and B row-major, then
// replays them as tagged (in1, in2) pairs under a valid/ready handshake.
//
// state  | meaning
// IDLE   | waiting for start; counters parked at (0,0)
// LOAD   | load_ready=1; each load_valid writes A/B at (i,j) and advances
// STREAM | out_valid=1; pair (i,j) presented, advances on out_ready
// DONE   | one-cycle done pulse, then back to IDLE
module ntm_matrix_adder_feeder
    import ntm_matrix_adder_pkg::*;
#(
    parameter int DATA_SIZE  = DEFAULT_DATA_SIZE,
    parameter int SIZE_I     = 4,
    parameter int SIZE_J     = 4,
    parameter int INDEX_SIZE = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  load_valid,
    output logic                  load_ready,
    input  logic [DATA_SIZE-1:0]  load_a,
    input  logic [DATA_SIZE-1:0]  load_b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_SIZE-1:0]  in1,
    output logic [DATA_SIZE-1:0]  in2,
    output logic [INDEX_SIZE-1:0] out_i,
    output logic [INDEX_SIZE-1:0] out_j,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done
);

    localparam logic [INDEX_SIZE-1:0] LAST_I = INDEX_SIZE'(SIZE_I - 1);
    localparam logic [INDEX_SIZE-1:0] LAST_J = INDEX_SIZE'(SIZE_J - 1);

    state_t                state, state_nxt;
    logic [INDEX_SIZE-1:0] i, j, i_nxt, j_nxt;
    logic                  at_end;
    logic                  adv;
    logic [DATA_SIZE-1:0]  rd_a, rd_b;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            i     <= '0;
            j     <= '0;
        end else begin
            state <= state_nxt;
            i     <= i_nxt;
            j     <= j_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        i_nxt     = i;
        j_nxt     = j;
        adv       = 1'b0;
        at_end    = (i == LAST_I) && (j == LAST_J);
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = LOAD;
                    i_nxt     = '0;
                    j_nxt     = '0;
                end
            end
            LOAD: begin
                adv = load_valid;
                if (load_valid && at_end) state_nxt = STREAM;
            end
            STREAM: begin
                adv = out_ready;
                if (out_ready && at_end) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        // Row-major walk; the final element returns the counters to (0,0) for the next phase.
        if (adv) begin
            if (at_end) begin
                i_nxt = '0;
                j_nxt = '0;
            end else if (j == LAST_J) begin
                i_nxt = i + INDEX_SIZE'(1);
                j_nxt = '0;
            end else begin
                j_nxt = j + INDEX_SIZE'(1);
            end
        end
    end

    ntm_matrix_adder_buffer #(
        .DATA_SIZE  (DATA_SIZE),
        .SIZE_I     (SIZE_I),
        .SIZE_J     (SIZE_J),
        .INDEX_SIZE (INDEX_SIZE)
    ) u_buffer (
        .clk  (clk),
        .we   (load_ready && load_valid),
        .wr_i (i),
        .wr_j (j),
        .wr_a (load_a),
        .wr_b (load_b),
        .rd_i (i),
        .rd_j (j),
        .rd_a (rd_a),
        .rd_b (rd_b)
    );

    assign load_ready = (state == LOAD);
    assign out_valid  = (state == STREAM);
    assign busy       = (state != IDLE);
    assign done       = (state == DONE);

    // Pair outputs are forced to zero whenever no pair is being presented.
    assign in1      = out_valid ? rd_a : '0;
    assign in2      = out_valid ? rd_b : '0;
    assign out_i    = out_valid ? i : '0;
    assign out_j    = out_valid ? j : '0;
    assign out_last = out_valid && at_end;

endmodule

// File: tb/tb_ntm_matrix_adder_feeder.sv
// Scoreboard bench for the matrix adder feeder on a 2x2 configuration with a downstream adder model.
module tb_ntm_matrix_adder_feeder;
    import ntm_matrix_adder_pkg::*;

    localparam int DW = 8;
    localparam int SI = 2;
    localparam int SJ = 2;
    localparam int IW = 4;
    localparam int N  = SI * SJ;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          load_valid = 1'b0;
    logic          load_ready;
    logic [DW-1:0] load_a = '0;
    logic [DW-1:0] load_b = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] in1, in2;
    logic [IW-1:0] out_i, out_j;
    logic          out_last, busy, done;

    ntm_matrix_adder_feeder #(
        .DATA_SIZE(DW), .SIZE_I(SI), .SIZE_J(SJ), .INDEX_SIZE(IW)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .load_valid(load_valid), .load_ready(load_ready),
        .load_a(load_a), .load_b(load_b),
        .out_valid(out_valid), .out_ready(out_ready),
        .in1(in1), .in2(in2), .out_i(out_i), .out_j(out_j),
        .out_last(out_last), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [24:0] pkt;
        logic [8:0]  sum;
    } exp_t;

    exp_t  sb[$];
    int    tests = 0;
    int    fails = 0;
    int    done_cnt = 0;
    elem_t op_a[N];
    elem_t op_b[N];
    int    bp[$];

    function automatic logic [24:0] pack(input logic [7:0] a, input logic [7:0] b,
                                         input logic [3:0] ri, input logic [3:0] cj,
                                         input logic l);
        return {a, b, ri, cj, l};
    endfunction

    task automatic check_eq(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    // Downstream registered 9-bit adder fed by the DUT pair outputs.
    logic [8:0] sum_q;
    always @(posedge clk) sum_q <= {1'b0, in1} + {1'b0, in2};

    bit          held_prev = 0;
    logic [24:0] held_pkt;
    bit          last_acc_prev = 0;
    bit          sum_pend = 0;
    logic [8:0]  sum_exp;

    always @(negedge clk) begin
        if (rst) begin
            held_prev     = 0;
            last_acc_prev = 0;
            sum_pend      = 0;
        end else begin
            if (sum_pend) check_eq("adder_sum", int'(sum_q), int'(sum_exp));
            sum_pend = 0;
            if (held_prev)
                check_eq("hold_stable", int'({out_valid, pack(in1, in2, out_i, out_j, out_last)}),
                         int'({1'b1, held_pkt}));
            if (done || last_acc_prev) check_eq("done_after_last", int'(done), int'(last_acc_prev));
            if (done) done_cnt++;
            if (busy && !out_valid)
                check_eq("zero_when_invalid", int'(pack(in1, in2, out_i, out_j, out_last)), 0);
            last_acc_prev = 0;
            held_prev     = 0;
            if (out_valid) begin
                if (out_ready) begin
                    if (sb.size() == 0) begin
                        check_eq("unexpected_pair", int'(pack(in1, in2, out_i, out_j, out_last)), -1);
                    end else begin
                        exp_t e;
                        e = sb.pop_front();
                        check_eq("pair", int'(pack(in1, in2, out_i, out_j, out_last)), int'(e.pkt));
                        sum_exp  = e.sum;
                        sum_pend = 1;
                    end
                    last_acc_prev = out_last;
                end else begin
                    held_prev = 1;
                    held_pkt  = pack(in1, in2, out_i, out_j, out_last);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_random();
        for (int k = 0; k < N; k++) begin
            op_a[k] = elem_t'($urandom_range(0, 255));
            op_b[k] = elem_t'($urandom_range(0, 255));
        end
    endtask

    // Cycles from first out_valid until done, given the ready pattern (1 after it runs out).
    function automatic int expected_stream_cycles();
        int ones = 0;
        int k = 0;
        while (ones < N) begin
            if (k >= bp.size() || bp[k] != 0) ones++;
            k++;
        end
        return k;
    endfunction

    task automatic run_op(input int stall_at, input int stall_len,
                          input bit start_in_load, input bit abort);
        int cyc;
        int exp_cyc;
        int d0;
        d0 = done_cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
        check_eq("load_ready_in_load", int'(load_ready), 1);
        for (int k = 0; k < N; k++) begin
            if (k == stall_at) begin
                load_valid = 1'b0;
                for (int s = 0; s < stall_len; s++) begin
                    tick();
                    check_eq("load_ready_stall", int'(load_ready), 1);
                end
            end
            load_valid = 1'b1;
            load_a     = op_a[k];
            load_b     = op_b[k];
            start      = start_in_load && (k == 1);
            sb.push_back('{pack(op_a[k], op_b[k], 4'(k / SJ), 4'(k % SJ), k == N - 1),
                           {1'b0, op_a[k]} + {1'b0, op_b[k]}});
            tick();
            start = 1'b0;
        end
        load_valid = 1'b0;
        check_eq("load_ready_drop", int'(load_ready), 0);
        check_eq("first_out_valid", int'(out_valid), 1);
        if (abort) begin
            out_ready = 1'b1;
            tick();
            tick();
            rst       = 1'b1;
            out_ready = 1'b0;
            tick();
            rst = 1'b0;
            check_eq("abort_out_valid", int'(out_valid), 0);
            check_eq("abort_busy", int'(busy), 0);
            sb.delete();
            repeat (3) tick();
            check_eq("abort_no_done", done_cnt, d0);
            return;
        end
        exp_cyc = expected_stream_cycles();
        cyc = 0;
        while (!done && cyc < 200) begin
            out_ready = (cyc < bp.size()) ? (bp[cyc] != 0) : 1'b1;
            tick();
            cyc++;
        end
        check_eq("stream_cycles", cyc, exp_cyc);
        out_ready = 1'b0;
        tick();
        check_eq("done_one_cycle", int'(done), 0);
        check_eq("idle_after_done", int'(busy), 0);
        check_eq("scoreboard_empty", sb.size(), 0);
        check_eq("done_pulses", done_cnt - d0, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) tick();
        rst = 1'b0;
        check_eq("reset_outputs",
                 int'({load_ready, out_valid, out_last, busy, done, in1, in2, out_i, out_j}), 0);

        for (int k = 0; k < N; k++) begin
            op_a[k] = elem_t'(k + 1);
            op_b[k] = elem_t'(10 * (k + 1));
        end
        bp.delete();
        run_op(-1, 0, 0, 0);

        for (int k = 0; k < N; k++) begin
            op_a[k] = 8'hFF;
            op_b[k] = 8'hFF;
        end
        run_op(-1, 0, 0, 0);

        fill_random();
        bp = '{1, 0, 0, 1, 1, 1};
        run_op(-1, 0, 0, 0);

        fill_random();
        bp.delete();
        run_op(2, 3, 0, 0);

        fill_random();
        run_op(-1, 0, 1, 1);

        fill_random();
        run_op(-1, 0, 0, 0);

        for (int r = 0; r < 6; r++) begin
            fill_random();
            bp.delete();
            for (int k = 0; k < 8; k++) bp.push_back(int'($urandom_range(0, 1)));
            run_op(int'($urandom_range(0, N)), int'($urandom_range(0, 3)), 0, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ntm_matrix_adder_feeder.md
Name: ntm_matrix_adder_feeder

Overview:
Upstream operand sequencer for the 8-bit registered element adder in the matrix-arithmetic adder path.
- Captures two SIZE_I x SIZE_J operand matrices A and B, streamed in row-major order, into local storage.
- Replays them as element pairs (in1, in2) with row/column tags and a valid/ready handshake.
- The adder's registered 9-bit sum appears one cycle after each accepted pair; the downstream collector tags it using out_valid, out_i, out_j and out_last delayed by one cycle.

Parameters:
DATA_SIZE, 8, element width of A and B; equals the adder input width.
SIZE_I, 4, matrix rows, 1..16.
SIZE_J, 4, matrix columns, 1..16.
INDEX_SIZE, 4, width of the row/column tags; must satisfy 2**INDEX_SIZE >= max(SIZE_I, SIZE_J).

Ports:
clk  input  1  single clock, rising edge
rst  input  1  synchronous, active-high reset
start  input  1  begin a load+stream operation; accepted only in IDLE
load_valid  input  1  load_a/load_b carry the next row-major element pair
load_ready  output  1  feeder accepts a pair this cycle
load_a  input  DATA_SIZE  element of A
load_b  input  DATA_SIZE  element of B
out_valid  output  1  in1/in2 hold a valid pair
out_ready  input  1  consumer accepts the pair this cycle
in1  output  DATA_SIZE  A[i][j], to adder in1
in2  output  DATA_SIZE  B[i][j], to adder in2
out_i  output  INDEX_SIZE  row tag of the current pair
out_j  output  INDEX_SIZE  column tag of the current pair
out_last  output  1  current pair is (SIZE_I-1, SIZE_J-1)
busy  output  1  high in LOAD, STREAM and DONE
done  output  1  one-cycle pulse after the last pair is accepted

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - Outputs: state=IDLE; load_ready, out_valid, out_last, busy, done = 0; in1, in2, out_i, out_j = 0.
  - Storage contents are not cleared and are don't-care.
  - Reset mid-LOAD or mid-STREAM aborts the operation immediately; no done pulse.
- States: IDLE, LOAD, STREAM, DONE.
- IDLE:
  - start=1 -> LOAD next cycle; row/column counters i, j cleared to 0.
  - start is ignored in every other state.
- LOAD:
  - load_ready=1.
  - Each cycle with load_valid && load_ready writes A[i][j]=load_a and B[i][j]=load_b, then advances j; when j wraps from SIZE_J-1 to 0, i increments.
  - After the pair at (SIZE_I-1, SIZE_J-1) is written, the next state is STREAM with i=j=0.
  - load_ready drops in the cycle after the final write.
  - load_valid=0 stalls with no state change.
- STREAM:
  - out_valid=1; in1=A[i][j], in2=B[i][j], out_i=i, out_j=j, out_last=(i==SIZE_I-1 && j==SIZE_J-1).
  - First out_valid occurs the cycle after the final load write; there are no bubbles while out_ready=1.
  - out_ready=0: in1, in2, out_i, out_j and out_last hold stable; no advance.
  - out_valid && out_ready: advance in the same row-major order. If out_last=1, go to DONE.
- DONE: done=1 and out_valid=0 for exactly one cycle -> IDLE.
- When out_valid=0, in1, in2, out_i, out_j and out_last are driven to 0.
- Throughput: one pair per cycle in both LOAD and STREAM. Minimum operation length is 1 + 2*SIZE_I*SIZE_J + 1 cycles from start.
- Width rules: no arithmetic on data in this block. Counters are INDEX_SIZE bits and compare against SIZE-1; no wrap beyond SIZE.
- Degenerate 1x1 matrix: the single load goes straight to STREAM; the first pair has out_last=1.

Decomposition:
- Package ntm_matrix_adder_pkg holds:
  - the state enum type (IDLE, LOAD, STREAM, DONE);
  - the DATA_SIZE default constant;
  - the element typedef logic [DATA_SIZE-1:0].
- One natural sub-module, ntm_matrix_adder_buffer: a dual SIZE_I*SIZE_J x DATA_SIZE register array with one synchronous write port and one combinational read port, indexed by (i, j). The FSM and counters stay in the top level.

Test Plan:
- Basic 2x2 (SIZE_I=SIZE_J=2), continuous handshake: start, then load A={1,2,3,4}, B={10,20,30,40} with load_valid=1 and out_ready=1.
  - Required: pairs (1,10) (2,20) (3,30) (4,40) on consecutive cycles with tags (0,0) (0,1) (1,0) (1,1).
  - out_last on the 4th pair; done one cycle later.
  - Adder output: 11, 22, 33, 44.
- Overflow operands: A all 255, B all 255.
  - Required: every pair is (255,255); the adder sum is 510 (9'h1FE) for all 4 elements.
- Backpressure: during STREAM, out_ready toggles 1,0,0,1,1,1.
  - Required: pairs hold stable while out_ready=0; no element is skipped or duplicated; done follows acceptance of element 4.
- Load stalls: load_valid=0 for 3 cycles between elements 2 and 3.
  - Required: load_ready stays 1; elements are stored in the correct slots; the stream order is unchanged.
- Start ignored and reset mid-stream:
  - start pulsed during LOAD: no effect.
  - rst asserted after 2 pairs are accepted: next cycle state=IDLE, out_valid=0, busy=0, no done pulse.
  - A new start then performs a complete operation correctly.
